// File: rtl/mcs4_pkg.sv
// Shared types for the MCS-4 debug path: nibble/byte types, debug address,
// AXI response codes and the bridge FSM state encoding.
package mcs4;

  typedef logic [3:0] char_t;
  typedef logic [7:0] byte_t;
  typedef char_t [2:0] dbg_addr_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    WR_COLLECT,
    WR_EXEC,
    WR_RESP,
    RD_WAIT,
    RD_RESP
  } axil_state_t;

endpackage

// File: rtl/axil_dbg_bridge_if.sv
// AXI4-Lite slave channel bundle used between the PS interconnect and the
// debug bridge.
interface axil_dbg_bridge_if #(
    parameter int AXI_ADDR_W = 16
);
    logic [AXI_ADDR_W-1:0] s_axi_awaddr;
    logic                  s_axi_awvalid;
    logic                  s_axi_awready;
    logic [31:0]           s_axi_wdata;
    logic [3:0]            s_axi_wstrb;
    logic                  s_axi_wvalid;
    logic                  s_axi_wready;
    logic [1:0]            s_axi_bresp;
    logic                  s_axi_bvalid;
    logic                  s_axi_bready;
    logic [AXI_ADDR_W-1:0] s_axi_araddr;
    logic                  s_axi_arvalid;
    logic                  s_axi_arready;
    logic [31:0]           s_axi_rdata;
    logic [1:0]            s_axi_rresp;
    logic                  s_axi_rvalid;
    logic                  s_axi_rready;

    modport master (
        output s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
               s_axi_bready, s_axi_araddr, s_axi_arvalid, s_axi_rready,
        input  s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
               s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid
    );

    modport slave (
        input  s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
               s_axi_bready, s_axi_araddr, s_axi_arvalid, s_axi_rready,
        output s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
               s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid
    );
endinterface

// File: rtl/axil_dbg_bridge.sv
// AXI4-Lite slave to single-cycle debug bus bridge feeding dbg_ctl.
// One transaction in flight; 8-bit debug data zero-extended onto 32 bits.
module axil_dbg_bridge
    import mcs4::*;
#(
    parameter int AXI_ADDR_W = 16,
    parameter int ADDR_LSB   = 2,
    parameter int RD_LAT     = 1
) (
    input  logic             clk,
    input  logic             rst,
    axil_dbg_bridge_if.slave s_axi,
    output dbg_addr_t        dbg_addr,
    output byte_t            dbg_wdata,
    output logic             dbg_wen,
    input  byte_t            dbg_rdata
);

    axil_state_t state, state_next;

    logic                  live;
    logic                  have_aw, have_w, wstrb0_q, wr_ok, rd_ok;
    logic [AXI_ADDR_W-1:0] awaddr_q, wr_addr;
    logic [1:0]            cnt, bresp_q, rresp_q;
    logic [31:0]           rdata_q;
    logic                  aw_hs, w_hs, ar_hs, wr_start;
    logic                  unused_ok;

    function automatic logic in_range(input logic [AXI_ADDR_W-1:0] a);
        return (a >> (ADDR_LSB + 12)) == '0;
    endfunction

    function automatic dbg_addr_t word_idx(input logic [AXI_ADDR_W-1:0] a);
        return a[ADDR_LSB +: 12];
    endfunction

    assign aw_hs    = s_axi.s_axi_awvalid && s_axi.s_axi_awready;
    assign w_hs     = s_axi.s_axi_wvalid  && s_axi.s_axi_wready;
    assign ar_hs    = s_axi.s_axi_arvalid && s_axi.s_axi_arready;
    assign wr_start = (state_next == WR_EXEC);
    assign wr_addr  = have_aw ? awaddr_q : s_axi.s_axi_awaddr;

    assign s_axi.s_axi_bresp = bresp_q;
    assign s_axi.s_axi_rresp = rresp_q;
    assign s_axi.s_axi_rdata = rdata_q;
    assign unused_ok = &{1'b0, s_axi.s_axi_wdata[31:8], s_axi.s_axi_wstrb[3:1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (aw_hs && w_hs)      state_next = WR_EXEC;
                else if (aw_hs || w_hs) state_next = WR_COLLECT;
                else if (ar_hs)         state_next = RD_WAIT;
            end
            WR_COLLECT: if ((have_aw || aw_hs) && (have_w || w_hs)) state_next = WR_EXEC;
            WR_EXEC:    state_next = WR_RESP;
            WR_RESP:    if (s_axi.s_axi_bready) state_next = IDLE;
            RD_WAIT:    if (cnt == 2'd1) state_next = RD_RESP;
            RD_RESP:    if (s_axi.s_axi_rready) state_next = IDLE;
            default:    state_next = IDLE;
        endcase
    end

    // live keeps every ready low while rst is held and for the first cycle after.
    always_comb begin
        s_axi.s_axi_awready = 1'b0;
        s_axi.s_axi_wready  = 1'b0;
        s_axi.s_axi_arready = 1'b0;
        s_axi.s_axi_bvalid  = 1'b0;
        s_axi.s_axi_rvalid  = 1'b0;
        dbg_wen             = 1'b0;
        unique case (state)
            IDLE: begin
                s_axi.s_axi_awready = live;
                s_axi.s_axi_wready  = live;
                s_axi.s_axi_arready = live && !s_axi.s_axi_awvalid && !s_axi.s_axi_wvalid;
            end
            WR_COLLECT: begin
                s_axi.s_axi_awready = !have_aw;
                s_axi.s_axi_wready  = !have_w;
            end
            WR_EXEC: dbg_wen            = wr_ok && wstrb0_q;
            WR_RESP: s_axi.s_axi_bvalid = 1'b1;
            RD_RESP: s_axi.s_axi_rvalid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            live      <= 1'b0;
            have_aw   <= 1'b0;
            have_w    <= 1'b0;
            wstrb0_q  <= 1'b0;
            wr_ok     <= 1'b0;
            rd_ok     <= 1'b0;
            awaddr_q  <= '0;
            cnt       <= '0;
            bresp_q   <= '0;
            rresp_q   <= '0;
            rdata_q   <= '0;
            dbg_addr  <= '0;
            dbg_wdata <= '0;
        end else begin
            live <= 1'b1;
            if (aw_hs) begin
                awaddr_q <= s_axi.s_axi_awaddr;
                have_aw  <= 1'b1;
            end
            if (w_hs) begin
                dbg_wdata <= s_axi.s_axi_wdata[7:0];
                wstrb0_q  <= s_axi.s_axi_wstrb[0];
                have_w    <= 1'b1;
            end
            // Collection flags clear as the write launches, overriding any same-cycle set.
            if (wr_start) begin
                have_aw <= 1'b0;
                have_w  <= 1'b0;
                wr_ok   <= in_range(wr_addr);
                bresp_q <= in_range(wr_addr) ? RESP_OKAY : RESP_SLVERR;
                if (in_range(wr_addr)) dbg_addr <= word_idx(wr_addr);
            end
            if (ar_hs) begin
                rd_ok   <= in_range(s_axi.s_axi_araddr);
                rresp_q <= in_range(s_axi.s_axi_araddr) ? RESP_OKAY : RESP_SLVERR;
                cnt     <= 2'(RD_LAT);
                if (in_range(s_axi.s_axi_araddr)) dbg_addr <= word_idx(s_axi.s_axi_araddr);
            end
            if (state == RD_WAIT) begin
                cnt <= cnt - 2'd1;
                if (cnt == 2'd1) rdata_q <= rd_ok ? {24'b0, dbg_rdata} : '0;
            end
        end
    end

endmodule

// File: tb/tb_axil_dbg_bridge.sv
// Directed bench for axil_dbg_bridge: vector table of single accesses plus
// hand-built sequences for split writes, AR/W contention, RD_LAT=3 and reset.
module tb_axil_dbg_bridge;
    import mcs4::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    axil_dbg_bridge_if #(.AXI_ADDR_W(16)) bus0 ();
    axil_dbg_bridge_if #(.AXI_ADDR_W(16)) bus1 ();

    dbg_addr_t dbg_addr0, dbg_addr1;
    byte_t     dbg_wdata0, dbg_wdata1, dbg_rdata0, dbg_rdata1;
    logic      dbg_wen0, dbg_wen1;

    axil_dbg_bridge #(.AXI_ADDR_W(16), .ADDR_LSB(2), .RD_LAT(1)) dut0 (
        .clk(clk), .rst(rst), .s_axi(bus0),
        .dbg_addr(dbg_addr0), .dbg_wdata(dbg_wdata0), .dbg_wen(dbg_wen0), .dbg_rdata(dbg_rdata0)
    );

    axil_dbg_bridge #(.AXI_ADDR_W(16), .ADDR_LSB(2), .RD_LAT(3)) dut1 (
        .clk(clk), .rst(rst), .s_axi(bus1),
        .dbg_addr(dbg_addr1), .dbg_wdata(dbg_wdata1), .dbg_wen(dbg_wen1), .dbg_rdata(dbg_rdata1)
    );

    // Debug target stubs: 0xEE everywhere except word 1 = 0x5A after reset.
    byte_t mem0 [4096];
    byte_t mem1 [4096];
    byte_t p1, p2;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4096; i++) mem0[i] <= 8'hEE;
            mem0[1] <= 8'h5A;
        end else if (dbg_wen0) begin
            mem0[dbg_addr0] <= dbg_wdata0;
        end
    end
    assign dbg_rdata0 = mem0[dbg_addr0];

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4096; i++) mem1[i] <= 8'hEE;
            mem1[1] <= 8'h5A;
        end else if (dbg_wen1) begin
            mem1[dbg_addr1] <= dbg_wdata1;
        end
        p1 <= mem1[dbg_addr1];
        p2 <= p1;
    end
    assign dbg_rdata1 = p2;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    task automatic axil_write(input logic [15:0] addr, input logic [31:0] data, input logic [3:0] strb,
                              output logic [1:0] resp, output int wen_cnt,
                              output logic [11:0] wa, output logic [7:0] wd, output int lat);
        int t;
        resp = '1; wen_cnt = 0; wa = '0; wd = '0; lat = -1;
        @(posedge clk); #1;
        bus0.s_axi_awaddr = addr; bus0.s_axi_wdata = data; bus0.s_axi_wstrb = strb;
        bus0.s_axi_awvalid = 1'b1; bus0.s_axi_wvalid = 1'b1;
        t = 0;
        do begin @(negedge clk); t++; end
        while (!(bus0.s_axi_awready && bus0.s_axi_wready) && t < 50);
        check("wr_accept", 32'(bus0.s_axi_awready && bus0.s_axi_wready), 32'd1);
        if (!(bus0.s_axi_awready && bus0.s_axi_wready)) begin
            bus0.s_axi_awvalid = 1'b0; bus0.s_axi_wvalid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        bus0.s_axi_awvalid = 1'b0; bus0.s_axi_wvalid = 1'b0;
        for (t = 0; t < 50; t++) begin
            @(negedge clk);
            lat = t + 1;
            if (dbg_wen0) begin wen_cnt++; wa = dbg_addr0; wd = dbg_wdata0; end
            if (bus0.s_axi_bvalid) break;
        end
        if (!bus0.s_axi_bvalid) begin timeout("wr_bvalid"); return; end
        resp = bus0.s_axi_bresp;
        bus0.s_axi_bready = 1'b1;
        @(posedge clk); #1;
        bus0.s_axi_bready = 1'b0;
        @(negedge clk);
        if (dbg_wen0) wen_cnt++;
    endtask

    task automatic axil_read(input logic [15:0] addr, output logic [31:0] data,
                             output logic [1:0] resp, output int lat);
        int t;
        data = '1; resp = '1; lat = -1;
        @(posedge clk); #1;
        bus0.s_axi_araddr = addr; bus0.s_axi_arvalid = 1'b1;
        t = 0;
        do begin @(negedge clk); t++; end
        while (!bus0.s_axi_arready && t < 50);
        check("rd_accept", 32'(bus0.s_axi_arready), 32'd1);
        if (!bus0.s_axi_arready) begin bus0.s_axi_arvalid = 1'b0; return; end
        @(posedge clk); #1;
        bus0.s_axi_arvalid = 1'b0;
        for (t = 0; t < 50; t++) begin
            @(negedge clk);
            lat = t + 1;
            if (bus0.s_axi_rvalid) break;
        end
        if (!bus0.s_axi_rvalid) begin timeout("rd_rvalid"); return; end
        data = bus0.s_axi_rdata;
        resp = bus0.s_axi_rresp;
        bus0.s_axi_rready = 1'b1;
        @(posedge clk); #1;
        bus0.s_axi_rready = 1'b0;
    endtask

    typedef struct {
        bit          wr;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        int          exp_wen;
        logic [11:0] exp_daddr;
        logic [7:0]  exp_dwdata;
        logic [1:0]  exp_resp;
        logic [31:0] exp_rdata;
    } vec_t;

    localparam int NV = 12;
    vec_t vecs [NV];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  resp;
        logic [31:0] rd;
        logic [11:0] wa;
        logic [7:0]  wd;
        int          wen_cnt, lat, t;

        vecs[0]  = '{1'b1, 16'h0010, 32'h0000_00A5, 4'h1, 1, 12'h004, 8'hA5, 2'b00, 32'h0};
        vecs[1]  = '{1'b0, 16'h0010, 32'h0,         4'h0, 0, 12'h000, 8'h00, 2'b00, 32'h0000_00A5};
        vecs[2]  = '{1'b1, 16'h4000, 32'h0000_0077, 4'h1, 0, 12'h000, 8'h00, 2'b10, 32'h0};
        vecs[3]  = '{1'b1, 16'h0010, 32'h0000_0011, 4'h0, 0, 12'h000, 8'h00, 2'b00, 32'h0};
        vecs[4]  = '{1'b0, 16'h0010, 32'h0,         4'h0, 0, 12'h000, 8'h00, 2'b00, 32'h0000_00A5};
        vecs[5]  = '{1'b0, 16'h4000, 32'h0,         4'h0, 0, 12'h000, 8'h00, 2'b10, 32'h0};
        vecs[6]  = '{1'b1, 16'h3FFC, 32'hDEAD_BEC3, 4'hF, 1, 12'hFFF, 8'hC3, 2'b00, 32'h0};
        vecs[7]  = '{1'b0, 16'h3FFC, 32'h0,         4'h0, 0, 12'h000, 8'h00, 2'b00, 32'h0000_00C3};
        vecs[8]  = '{1'b0, 16'h0004, 32'h0,         4'h0, 0, 12'h000, 8'h00, 2'b00, 32'h0000_005A};
        vecs[9]  = '{1'b0, 16'h0007, 32'h0,         4'h0, 0, 12'h000, 8'h00, 2'b00, 32'h0000_005A};
        vecs[10] = '{1'b1, 16'h8010, 32'h0000_0022, 4'h1, 0, 12'h000, 8'h00, 2'b10, 32'h0};
        vecs[11] = '{1'b0, 16'h0000, 32'h0,         4'h0, 0, 12'h000, 8'h00, 2'b00, 32'h0000_00EE};

        bus0.s_axi_awaddr = '0; bus0.s_axi_awvalid = 0; bus0.s_axi_wdata = '0; bus0.s_axi_wstrb = '0;
        bus0.s_axi_wvalid = 0; bus0.s_axi_bready = 0; bus0.s_axi_araddr = '0; bus0.s_axi_arvalid = 0;
        bus0.s_axi_rready = 0;
        bus1.s_axi_awaddr = '0; bus1.s_axi_awvalid = 0; bus1.s_axi_wdata = '0; bus1.s_axi_wstrb = '0;
        bus1.s_axi_wvalid = 0; bus1.s_axi_bready = 0; bus1.s_axi_araddr = '0; bus1.s_axi_arvalid = 0;
        bus1.s_axi_rready = 0;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_awready", 32'(bus0.s_axi_awready), 0);
        check("rst_wready",  32'(bus0.s_axi_wready),  0);
        check("rst_arready", 32'(bus0.s_axi_arready), 0);
        check("rst_bvalid",  32'(bus0.s_axi_bvalid),  0);
        check("rst_rvalid",  32'(bus0.s_axi_rvalid),  0);
        check("rst_dbg_wen", 32'(dbg_wen0), 0);
        check("rst_dbg_addr", 32'(dbg_addr0), 0);
        check("rst_rdata",   bus0.s_axi_rdata, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_awready", 32'(bus0.s_axi_awready), 1);
        check("idle_arready", 32'(bus0.s_axi_arready), 1);

        // Vector table: AW+W together, single reads
        for (int i = 0; i < NV; i++) begin
            if (vecs[i].wr) begin
                axil_write(vecs[i].addr, vecs[i].wdata, vecs[i].strb, resp, wen_cnt, wa, wd, lat);
                check($sformatf("v%0d_bresp", i), 32'(resp), 32'(vecs[i].exp_resp));
                check($sformatf("v%0d_wen_count", i), 32'(wen_cnt), 32'(vecs[i].exp_wen));
                check($sformatf("v%0d_bvalid_lat", i), 32'(lat), 32'd2);
                if (vecs[i].exp_wen != 0) begin
                    check($sformatf("v%0d_dbg_addr", i), 32'(wa), 32'(vecs[i].exp_daddr));
                    check($sformatf("v%0d_dbg_wdata", i), 32'(wd), 32'(vecs[i].exp_dwdata));
                end
            end else begin
                axil_read(vecs[i].addr, rd, resp, lat);
                check($sformatf("v%0d_rresp", i), 32'(resp), 32'(vecs[i].exp_resp));
                check($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rdata);
                check($sformatf("v%0d_rvalid_lat", i), 32'(lat), 32'd2);
            end
        end

        // W arrives two cycles before AW
        @(posedge clk); #1;
        bus0.s_axi_awaddr = 16'h0008; bus0.s_axi_wdata = 32'h0000_003C; bus0.s_axi_wstrb = 4'h1;
        bus0.s_axi_wvalid = 1'b1;
        @(negedge clk);
        check("split_wready_idle", 32'(bus0.s_axi_wready), 1);
        @(posedge clk); #1;
        bus0.s_axi_wvalid = 1'b0;
        @(negedge clk);
        check("split_wready_dropped", 32'(bus0.s_axi_wready), 0);
        check("split_awready_held", 32'(bus0.s_axi_awready), 1);
        check("split_no_early_wen", 32'(dbg_wen0), 0);
        @(posedge clk); #1;
        bus0.s_axi_awvalid = 1'b1;
        @(negedge clk);
        check("split_awready", 32'(bus0.s_axi_awready), 1);
        @(posedge clk); #1;
        bus0.s_axi_awvalid = 1'b0;
        @(negedge clk);
        check("split_wen", 32'(dbg_wen0), 1);
        check("split_dbg_addr", 32'(dbg_addr0), 32'h002);
        check("split_dbg_wdata", 32'(dbg_wdata0), 32'h3C);
        @(negedge clk);
        check("split_wen_single", 32'(dbg_wen0), 0);
        check("split_bvalid", 32'(bus0.s_axi_bvalid), 1);
        check("split_bresp", 32'(bus0.s_axi_bresp), 0);
        bus0.s_axi_bready = 1'b1;
        @(posedge clk); #1;
        bus0.s_axi_bready = 1'b0;
        axil_read(16'h0008, rd, resp, lat);
        check("split_readback", rd, 32'h0000_003C);

        // AR contending with AW+W: write goes first, read sees new value
        @(posedge clk); #1;
        bus0.s_axi_awaddr = 16'h0020; bus0.s_axi_wdata = 32'h0000_0099; bus0.s_axi_wstrb = 4'h1;
        bus0.s_axi_araddr = 16'h0020;
        bus0.s_axi_awvalid = 1'b1; bus0.s_axi_wvalid = 1'b1; bus0.s_axi_arvalid = 1'b1;
        @(negedge clk);
        check("prio_arready_blocked", 32'(bus0.s_axi_arready), 0);
        check("prio_awready", 32'(bus0.s_axi_awready), 1);
        @(posedge clk); #1;
        bus0.s_axi_awvalid = 1'b0; bus0.s_axi_wvalid = 1'b0;
        @(negedge clk);
        check("prio_wen", 32'(dbg_wen0), 1);
        check("prio_dbg_addr", 32'(dbg_addr0), 32'h008);
        check("prio_arready_exec", 32'(bus0.s_axi_arready), 0);
        @(negedge clk);
        check("prio_bvalid", 32'(bus0.s_axi_bvalid), 1);
        bus0.s_axi_bready = 1'b1;
        @(posedge clk); #1;
        bus0.s_axi_bready = 1'b0;
        for (t = 0; t < 50; t++) begin
            @(negedge clk);
            if (bus0.s_axi_arready) break;
        end
        check("prio_ar_accepted", 32'(bus0.s_axi_arready), 1);
        @(posedge clk); #1;
        bus0.s_axi_arvalid = 1'b0;
        lat = -1;
        for (t = 0; t < 50; t++) begin
            @(negedge clk);
            lat = t + 1;
            if (bus0.s_axi_rvalid) break;
        end
        check("prio_rvalid_lat", 32'(lat), 32'd2);
        check("prio_rdata", bus0.s_axi_rdata, 32'h0000_0099);
        check("prio_rresp", 32'(bus0.s_axi_rresp), 0);
        bus0.s_axi_rready = 1'b1;
        @(posedge clk); #1;
        bus0.s_axi_rready = 1'b0;

        // RD_LAT = 3 instance
        @(posedge clk); #1;
        bus1.s_axi_araddr = 16'h0004; bus1.s_axi_arvalid = 1'b1;
        @(negedge clk);
        check("lat3_arready", 32'(bus1.s_axi_arready), 1);
        @(posedge clk); #1;
        bus1.s_axi_arvalid = 1'b0;
        lat = -1;
        for (t = 0; t < 50; t++) begin
            @(negedge clk);
            lat = t + 1;
            if (bus1.s_axi_rvalid) break;
        end
        check("lat3_rvalid_lat", 32'(lat), 32'd4);
        check("lat3_rdata", bus1.s_axi_rdata, 32'h0000_005A);
        check("lat3_rresp", 32'(bus1.s_axi_rresp), 0);
        bus1.s_axi_rready = 1'b1;
        @(posedge clk); #1;
        bus1.s_axi_rready = 1'b0;

        // Reset while a read response is stalled
        @(posedge clk); #1;
        bus0.s_axi_araddr = 16'h0004; bus0.s_axi_arvalid = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        bus0.s_axi_arvalid = 1'b0;
        for (t = 0; t < 50; t++) begin
            @(negedge clk);
            if (bus0.s_axi_rvalid) break;
        end
        check("stall_rvalid", 32'(bus0.s_axi_rvalid), 1);
        repeat (2) @(negedge clk);
        check("stall_rvalid_held", 32'(bus0.s_axi_rvalid), 1);
        check("stall_rdata_held", bus0.s_axi_rdata, 32'h0000_005A);
        rst = 1'b1;
        #1;
        check("arst_rvalid", 32'(bus0.s_axi_rvalid), 0);
        check("arst_rdata", bus0.s_axi_rdata, 0);
        check("arst_awready", 32'(bus0.s_axi_awready), 0);
        check("arst_wready", 32'(bus0.s_axi_wready), 0);
        check("arst_arready", 32'(bus0.s_axi_arready), 0);
        @(posedge clk);
        @(negedge clk);
        check("arst_arready_held", 32'(bus0.s_axi_arready), 0);
        rst = 1'b0;
        axil_read(16'h0004, rd, resp, lat);
        check("post_rst_rdata", rd, 32'h0000_005A);
        check("post_rst_rresp", 32'(resp), 0);
        check("post_rst_lat", 32'(lat), 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
